// File: rtl/mmio_periph_hub.sv
// Decoded MMIO register hub: ID, UART TX/RX FIFOs, status/irq, GPIO, PWM duty and sensor registers.
// Optional MTIME/MTIMECMP timer is enabled by defining MMIO_HUB_TIMER_EN.
module mmio_periph_hub #(
  parameter int unsigned WL         = 32,
  parameter int unsigned N_PWM      = 4,
  parameter int unsigned PWM_DC_WL  = 18,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GPIO_WL    = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_wr,
  input  logic [5:0]                 cmd_addr,
  input  logic [3:0]                 cmd_be,
  input  logic [WL-1:0]              cmd_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_error,
  output logic [WL-1:0]              rsp_data,
  input  logic                       tx_rdy,
  output logic                       tx_vld,
  output logic [7:0]                 tx_data,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic [GPIO_WL-1:0]         gpio_in,
  output logic [GPIO_WL-1:0]         gpio_out,
  output logic [N_PWM*PWM_DC_WL-1:0] pwm_dcycle,
  input  logic                       sensor_valid,
  input  logic [30:0]                sensor_data,
  output logic                       irq
);

  localparam int unsigned LvlW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam logic [31:0] IdValue = 32'h4D4D_0002;

  typedef enum logic [0:0] {StIdle, StGap} tx_st_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic [3:0] word;
  logic       rd_en, wr_en;
  logic       unused_addr;
  assign word        = cmd_addr[5:2];
  assign rd_en       = cmd_valid && !cmd_wr;
  assign wr_en       = cmd_valid && cmd_wr;
  assign cmd_ready   = 1'b1;
  assign unused_addr = ^cmd_addr[1:0];

  // TX FIFO
  logic [7:0]      tx_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wptr_q, tx_rptr_q;
  logic [LvlW-1:0] tx_lvl_q;
  logic            tx_full, tx_empty, tx_push, tx_pop, tx_push_ok, tx_pop_ok;
  assign tx_full    = (tx_lvl_q == LvlW'(FIFO_DEPTH));
  assign tx_empty   = (tx_lvl_q == '0);
  assign tx_push    = wr_en && (word == 4'd1) && cmd_be[0];
  assign tx_push_ok = tx_push && !tx_full;
  assign tx_pop_ok  = tx_pop && !tx_empty;

  // RX FIFO
  logic [7:0]      rx_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rx_wptr_q, rx_rptr_q;
  logic [LvlW-1:0] rx_lvl_q;
  logic            rx_full, rx_empty, rx_pop, rx_push_ok, rx_pop_ok;
  assign rx_full    = (rx_lvl_q == LvlW'(FIFO_DEPTH));
  assign rx_empty   = (rx_lvl_q == '0);
  assign rx_pop     = rd_en && (word == 4'd2);
  assign rx_push_ok = rx_valid && !rx_full;
  assign rx_pop_ok  = rx_pop && !rx_empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_lvl_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_lvl_q  <= '0;
    end else begin
      if (tx_push_ok) begin
        tx_mem_q[tx_wptr_q] <= cmd_wdata[7:0];
        tx_wptr_q           <= tx_wptr_q + PtrW'(1);
      end
      if (tx_pop_ok) tx_rptr_q <= tx_rptr_q + PtrW'(1);
      tx_lvl_q <= tx_lvl_q + LvlW'(tx_push_ok) - LvlW'(tx_pop_ok);
      if (rx_push_ok) begin
        rx_mem_q[rx_wptr_q] <= rx_data;
        rx_wptr_q           <= rx_wptr_q + PtrW'(1);
      end
      if (rx_pop_ok) rx_rptr_q <= rx_rptr_q + PtrW'(1);
      rx_lvl_q <= rx_lvl_q + LvlW'(rx_push_ok) - LvlW'(rx_pop_ok);
    end
  end

  // TX drain: one strobe, then a mandatory idle cycle
  tx_st_e     tx_st_q, tx_st_d;
  logic       tx_vld_q, tx_vld_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_vld_d  = 1'b0;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    unique case (tx_st_q)
      StIdle: begin
        if (tx_rdy && !tx_empty) begin
          tx_pop    = 1'b1;
          tx_vld_d  = 1'b1;
          tx_data_d = tx_mem_q[tx_rptr_q];
          tx_st_d   = StGap;
        end
      end
      StGap:   tx_st_d = StIdle;
      default: tx_st_d = StIdle;
    endcase
  end

  assign tx_vld  = tx_vld_q;
  assign tx_data = tx_data_q;

  // Status flags and configuration registers
  logic [7:0]           status, w1c, irq_en_q, irq_en_d;
  logic                 tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic                 sensor_new_q, sensor_new_d, timer_hit;
  logic [30:0]          sensor_data_q, sensor_data_d;
  logic [GPIO_WL-1:0]   gpio_out_q, gpio_out_d, gpio_meta_q, gpio_sync_q;
  logic [PWM_DC_WL-1:0] pwm_q [N_PWM];
  logic [PWM_DC_WL-1:0] pwm_d [N_PWM];
  logic                 irq_q;

  assign status = {timer_hit, sensor_new_q, rx_ovf_q, tx_ovf_q,
                   rx_full, !rx_empty, tx_empty, tx_full};
  assign w1c    = (wr_en && (word == 4'd3) && cmd_be[0]) ? cmd_wdata[7:0] : 8'd0;

  // Hardware set has priority over software clear
  assign tx_ovf_d      = (tx_push && tx_full) || (tx_ovf_q && !w1c[4]);
  assign rx_ovf_d      = (rx_valid && rx_full) || (rx_ovf_q && !w1c[5]);
  assign sensor_new_d  = sensor_valid ||
                         (sensor_new_q && !w1c[6] && !(rd_en && (word == 4'd7)));
  assign sensor_data_d = sensor_valid ? sensor_data : sensor_data_q;
  assign irq_en_d      = (wr_en && (word == 4'd4) && cmd_be[0]) ? cmd_wdata[7:0] : irq_en_q;
  assign gpio_out_d    = (wr_en && (word == 4'd5)) ?
                         GPIO_WL'(lane_merge(32'(gpio_out_q), cmd_wdata, cmd_be)) : gpio_out_q;

  always_comb begin
    for (int i = 0; i < N_PWM; i++) begin
      pwm_d[i] = pwm_q[i];
      if (wr_en && (word == 4'(8 + i))) begin
        pwm_d[i] = PWM_DC_WL'(lane_merge(32'(pwm_q[i]), cmd_wdata, cmd_be));
      end
    end
  end

  always_comb begin
    pwm_dcycle = '0;
    for (int i = 0; i < N_PWM; i++) pwm_dcycle[i*PWM_DC_WL +: PWM_DC_WL] = pwm_q[i];
  end

  assign gpio_out = gpio_out_q;
  assign irq      = irq_q;

`ifdef MMIO_HUB_TIMER_EN
  logic [31:0] mtime_q, mtimecmp_q;
  logic        timer_hit_q;
  assign timer_hit = timer_hit_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mtime_q     <= '0;
      mtimecmp_q  <= 32'hFFFF_FFFF;
      timer_hit_q <= 1'b0;
    end else begin
      mtime_q     <= (wr_en && (word == 4'd14)) ?
                     lane_merge(mtime_q, cmd_wdata, cmd_be) : mtime_q + 32'd1;
      if (wr_en && (word == 4'd15)) mtimecmp_q <= lane_merge(mtimecmp_q, cmd_wdata, cmd_be);
      timer_hit_q <= (mtime_q == mtimecmp_q) || (timer_hit_q && !w1c[7]);
    end
  end
`else
  assign timer_hit = 1'b0;
`endif

  // Read mux
  logic [31:0] rdata;
  logic        rerr;
  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    case (word)
      4'd0: rdata = IdValue;
      4'd1: rdata = 32'(tx_lvl_q);
      4'd2: if (!rx_empty) rdata = {1'b1, 23'd0, rx_mem_q[rx_rptr_q]};
      4'd3: rdata = {24'd0, status};
      4'd4: rdata = {24'd0, irq_en_q};
      4'd5: rdata = 32'(gpio_out_q);
      4'd6: rdata = 32'(gpio_sync_q);
      4'd7: rdata = {sensor_new_q, sensor_data_q};
`ifdef MMIO_HUB_TIMER_EN
      4'd14: rdata = mtime_q;
      4'd15: rdata = mtimecmp_q;
`endif
      default: begin
        rerr = 1'b1;
        for (int i = 0; i < N_PWM; i++) begin
          if (word == 4'(8 + i)) begin
            rdata = 32'(pwm_q[i]);
            rerr  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_st_q       <= StIdle;
      tx_vld_q      <= 1'b0;
      tx_data_q     <= '0;
      tx_ovf_q      <= 1'b0;
      rx_ovf_q      <= 1'b0;
      sensor_new_q  <= 1'b0;
      sensor_data_q <= '0;
      irq_en_q      <= '0;
      gpio_out_q    <= '0;
      gpio_meta_q   <= '0;
      gpio_sync_q   <= '0;
      irq_q         <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_data      <= '0;
      for (int i = 0; i < N_PWM; i++) pwm_q[i] <= '0;
    end else begin
      tx_st_q       <= tx_st_d;
      tx_vld_q      <= tx_vld_d;
      tx_data_q     <= tx_data_d;
      tx_ovf_q      <= tx_ovf_d;
      rx_ovf_q      <= rx_ovf_d;
      sensor_new_q  <= sensor_new_d;
      sensor_data_q <= sensor_data_d;
      irq_en_q      <= irq_en_d;
      gpio_out_q    <= gpio_out_d;
      gpio_meta_q   <= gpio_in;
      gpio_sync_q   <= gpio_meta_q;
      irq_q         <= |(status & irq_en_q);
      rsp_valid     <= rd_en;
      rsp_error     <= rd_en && rerr;
      rsp_data      <= rd_en ? WL'(rdata) : '0;
      for (int i = 0; i < N_PWM; i++) pwm_q[i] <= pwm_d[i];
    end
  end

endmodule

// File: doc/mmio_periph_hub.md
Name: mmio_periph_hub

Overview:
Parametrised memory-mapped peripheral hub between the VexRiscv dBus IO window and the board peripherals. It replaces the flat IO register array with a decoded register map. Additions over the flat array:
- byte-lane writes
- UART TX/RX byte FIFOs with overflow flags
- N PWM duty registers
- a read-clear distance-sensor register
- maskable interrupt output

Parameters:
WL, 32, bus data width (fixed 32 in this generation)
N_PWM, 4, number of PWM duty registers, 1..6
PWM_DC_WL, 18, duty-cycle width per PWM channel, ≤32
FIFO_DEPTH, 16, UART TX and RX FIFO depth, power of 2, ≥2
GPIO_WL, 8, GPIO in/out width, ≤32

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  bus command valid
cmd_ready  out  1  always 1 (single-cycle accept)
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  6  byte address; word index = cmd_addr[5:2]
cmd_be  in  4  write byte enables
cmd_wdata  in  32  write data
rsp_valid  out  1  read response valid
rsp_error  out  1  read of undefined offset
rsp_data  out  32  read data
tx_rdy  in  1  UART transmitter idle
tx_vld  out  1  UART transmit strobe
tx_data  out  8  UART transmit byte
rx_valid  in  1  UART received-byte strobe
rx_data  in  8  UART received byte
gpio_in  in  GPIO_WL  asynchronous inputs (buttons/switches)
gpio_out  out  GPIO_WL  LED/RGB outputs
pwm_dcycle  out  N_PWM*PWM_DC_WL  flat duty cycles, channel 0 in LSBs
sensor_valid  in  1  distance measurement strobe
sensor_data  in  31  distance ticks
irq  out  1  registered interrupt request

Behaviour:
- Reset (resetn=0, async): all registers, FIFOs, sticky flags, irq, tx_vld, rsp_* cleared to 0; gpio_out=0; pwm_dcycle=0.
- Reads: rsp_valid asserts exactly 1 cycle after an accepted read. Writes produce no response.
- Undefined offsets: reads return rsp_data=0 with rsp_error=1. Writes to them are ignored.
- Register map (word index):
  - 0 ID, read-only 0x4D4D_0002
  - 1 UART_TX: write with cmd_be[0] pushes wdata[7:0]. Read returns {16'd0, 8'd0, txlevel}.
  - 2 UART_RX: read pops one byte and returns {1'b1, 23'd0, byte}. If RX is empty, returns 0 and does not pop.
  - 3 STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_nonempty, bit3 rx_full, bit4 tx_ovf, bit5 rx_ovf, bit6 sensor_new, bit7 timer_hit. Bits 4–7 are sticky and write-1-to-clear. Hardware set in the same cycle as a W1C wins.
  - 4 IRQ_EN: 8-bit mask at STATUS bit positions, read/write, byte-laned.
  - 5 GPIO_OUT: read/write, byte-laned.
  - 6 GPIO_IN: read-only, value after a 2-flop synchroniser.
  - 7 SENSOR: read returns {sensor_new, data} and clears sensor_new. sensor_valid latches data and sets sensor_new. If sensor_valid coincides with the read: the read returns the old value and sensor_new stays 1.
  - 8..8+N_PWM-1 PWM_DCYCLE: byte-laned, bits above PWM_DC_WL read 0.
- FIFOs:
  - Level counters are $clog2(FIFO_DEPTH+1) bits; pointers wrap modulo FIFO_DEPTH.
  - A push is evaluated against fullness at cycle start. A push when full is dropped and sets the matching ovf flag, even if a pop occurs in the same cycle.
  - A pop when empty is a no-op.
  - A simultaneous push and pop on a non-full FIFO leaves the level unchanged.
- TX drain:
  - State IDLE: if tx_rdy=1 and TX is not empty, drive tx_vld=1 for one cycle with the head byte, pop it, and go to GAP.
  - State GAP: one cycle with tx_vld=0, then return to IDLE.
  - tx_vld is never high in two consecutive cycles.
- irq: registered as |(STATUS[7:0] & IRQ_EN[7:0]), so it follows the condition by 1 cycle. Bits 1 and 2 are level-sensitive.

Optional Feature:
Macro MMIO_HUB_TIMER_EN.
- Defined:
  - Offset 14 MTIME: 32-bit counter, +1 per clk, wraps, writable.
  - Offset 15 MTIMECMP: read/write, resets to 0xFFFF_FFFF.
  - The cycle after MTIME==MTIMECMP, STATUS bit7 timer_hit is set.
- Undefined: offsets 14/15 are undefined (rsp_error=1) and bit7 always reads 0.

Test Plan:
- Reset/ID: deassert resetn, read offset 0 → rsp_data=0x4D4D0002 one cycle later, rsp_error=0. Read offset 13 with N_PWM=4 → rsp_data=0, rsp_error=1.
- TX drain: tx_rdy=1, write 0x41, 0x42, 0x43 back-to-back → tx_vld pulses carry 0x41, 0x42, 0x43 in order, with ≥1 idle cycle between pulses.
- TX overflow: tx_rdy=0, write 17 bytes (DEPTH=16) → STATUS=0x11 (tx_full|tx_ovf). Write 0x10 to STATUS → bit4 clears.
- RX: pulse rx_valid with 0x5A → UART_RX read returns 0x8000005A. Next read returns 0. Enable IRQ_EN=0x04 → irq=1 while RX is non-empty.
- Byte lanes/sensor: write 0xFFFFFFFF to PWM1 with cmd_be=4'b0010 → pwm_dcycle channel 1 = 0x0FF00. Pulse sensor_valid with data 1234 → SENSOR reads 0x800004D2, then 0x000004D2.
- Timer (macro defined): write MTIMECMP=100, MTIME=90 → STATUS bit7 set 11 cycles after the MTIME write; irq=1 if IRQ_EN bit7=1.
